// File: rtl/aes_gcm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_gcm_pkg
//  Description : Shared GF(2^128) types, reduction constant, GHASH state
//                encoding and the multiply-by-x helper (GCM bit order).
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_gcm_pkg;

    typedef logic [127:0] gf128_t;

    // Reduction polynomial in GCM bit order ([127] = x^0)
    localparam gf128_t GF128_R = 128'hE1 << 120;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GET0 = 3'd1,
        GET1 = 3'd2,
        MUL  = 3'd3,
        OUT  = 3'd4
    } ghash_state_t;

    // Multiply by x: shift toward higher degree (lower index), reduce on x^128
    function automatic gf128_t gf128_mulx(input gf128_t v);
        return (v >> 1) ^ (v[0] ? GF128_R : '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gf128_digit_mul.sv
`default_nettype none
// ============================================================================
//  Module      : gf128_digit_mul
//  Description : Digit-serial GF(2^128) multiplier, p = a * b. Horner's rule
//                over b from x^127 down to x^0, DIGIT bits per cycle, so a
//                product takes 128/DIGIT cycles after the start cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module gf128_digit_mul
    import aes_gcm_pkg::*;
#(
    parameter int DIGIT = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] a,
    input  logic [127:0] b,
    output logic         done,
    output logic [127:0] p
);

    localparam int c_N_STEPS = 128 / DIGIT;
    localparam int c_CNT_W   = (c_N_STEPS > 1) ? $clog2(c_N_STEPS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N_STEPS - 1);

    gf128_t             r_a;
    gf128_t             r_b;
    gf128_t             r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    gf128_t             w_acc;

    // One digit of Horner evaluation; b[0] is the highest-degree coefficient
    always_comb begin
        w_acc = r_acc;
        for (int j = 0; j < DIGIT; j++) begin
            w_acc = gf128_mulx(w_acc) ^ (r_b[j] ? r_a : '0);
        end
    end

    // Operand capture on start, then one digit per cycle until the last step
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_acc  <= w_acc;
            r_b    <= r_b >> DIGIT;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Final product is presented combinationally during the last step
    assign done = r_busy && (r_cnt == c_LAST);
    assign p    = w_acc;

endmodule
`default_nettype wire

// File: rtl/ghash_agg2.sv
`default_nettype none
// ============================================================================
//  Module      : ghash_agg2
//  Description : Two-way aggregated GHASH. Folds block pairs per iteration as
//                Y' = (Y ^ X0)*H^2 ^ X1*H, an odd final block as (Y ^ X0)*H,
//                and hands the result out with a ready/valid handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module ghash_agg2
    import aes_gcm_pkg::*;
#(
    parameter int DIGIT = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] h1,
    input  logic [127:0] h2,
    input  logic         h_valid,
    input  logic [127:0] din,
    input  logic         din_valid,
    input  logic         din_last,
    output logic         din_ready,
    output logic [127:0] ghash,
    output logic         ghash_valid,
    input  logic         ghash_ready,
    output logic         GHASH_done
);

    ghash_state_t r_state;
    ghash_state_t w_state_next;
    gf128_t       r_y;
    gf128_t       r_x0;
    logic         r_last;

    logic         w_start;
    gf128_t       w_a_op1;
    gf128_t       w_a_op2;
    gf128_t       w_b_op1;
    gf128_t       w_b_op2;
    logic         w_done_a;
    logic         w_done_b;
    gf128_t       w_p_a;
    gf128_t       w_p_b;
    logic         w_abort;

    // Losing h_valid while a message is in flight throws the message away
    assign w_abort = !h_valid && (r_state inside {GET0, GET1, MUL});

    // Next-state, handshake outputs and multiplier operand selection
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_a_op1      = '0;
        w_a_op2      = '0;
        w_b_op1      = '0;
        w_b_op2      = '0;
        din_ready    = 1'b0;
        ghash_valid  = 1'b0;
        GHASH_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (h_valid) w_state_next = GET0;
            end
            GET0: begin
                din_ready = h_valid;
                if (!h_valid) begin
                    w_state_next = IDLE;
                end else if (din_valid) begin
                    if (din_last) begin
                        // Odd tail: only multiplier A does work
                        w_start      = 1'b1;
                        w_a_op1      = r_y ^ din;
                        w_a_op2      = h1;
                        w_state_next = MUL;
                    end else begin
                        w_state_next = GET1;
                    end
                end
            end
            GET1: begin
                din_ready = h_valid;
                if (!h_valid) begin
                    w_state_next = IDLE;
                end else if (din_valid) begin
                    w_start      = 1'b1;
                    w_a_op1      = r_y ^ r_x0;
                    w_a_op2      = h2;
                    w_b_op1      = din;
                    w_b_op2      = h1;
                    w_state_next = MUL;
                end
            end
            MUL: begin
                if (!h_valid) begin
                    w_state_next = IDLE;
                end else if (w_done_a && w_done_b) begin
                    w_state_next = r_last ? OUT : GET0;
                end
            end
            OUT: begin
                ghash_valid = 1'b1;
                if (ghash_ready) begin
                    GHASH_done   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register plus accumulator, first-block and last-flag capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_y     <= '0;
            r_x0    <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_abort) begin
                r_y <= '0;
            end else begin
                case (r_state)
                    GET0: begin
                        if (din_valid) begin
                            r_x0   <= din;
                            r_last <= din_last;
                        end
                    end
                    GET1: begin
                        if (din_valid) r_last <= din_last;
                    end
                    MUL: begin
                        if (w_done_a && w_done_b) r_y <= w_p_a ^ w_p_b;
                    end
                    OUT: begin
                        if (ghash_ready) r_y <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ghash = r_y;

    gf128_digit_mul #(.DIGIT(DIGIT)) u_mul_a (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .a     (w_a_op1),
        .b     (w_a_op2),
        .done  (w_done_a),
        .p     (w_p_a)
    );

    gf128_digit_mul #(.DIGIT(DIGIT)) u_mul_b (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .a     (w_b_op1),
        .b     (w_b_op2),
        .done  (w_done_b),
        .p     (w_p_b)
    );

endmodule
`default_nettype wire

// File: tb/tb_ghash_agg2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ghash_agg2
//  Description : Self-checking bench for ghash_agg2 against a sequential
//                single-multiply GHASH reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ghash_agg2;

    localparam int     DIGIT   = 32;
    localparam int     c_N     = 128 / DIGIT;
    localparam [127:0] c_H     = 128'hacbef20579b4b8ebce889bac8732dad7;
    localparam [127:0] c_H2    = 128'hdb9f3b4948607beb8bb753ba40ab627b;
    localparam [127:0] c_H4    = 128'hb94efa0be54358f908c0c7fc88d48db2;
    localparam [127:0] c_ONE   = {1'b1, 127'b0};

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] h1, h2;
    logic         h_valid;
    logic [127:0] din;
    logic         din_valid, din_last;
    logic         din_ready;
    logic [127:0] ghash;
    logic         ghash_valid;
    logic         ghash_ready;
    logic         GHASH_done;

    int           n_chk  = 0;
    int           n_pass = 0;
    int           done_cnt = 0;
    logic [127:0] msg[$];

    ghash_agg2 #(.DIGIT(DIGIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .h1          (h1),
        .h2          (h2),
        .h_valid     (h_valid),
        .din         (din),
        .din_valid   (din_valid),
        .din_last    (din_last),
        .din_ready   (din_ready),
        .ghash       (ghash),
        .ghash_valid (ghash_valid),
        .ghash_ready (ghash_ready),
        .GHASH_done  (GHASH_done)
    );

    always #5 clk = ~clk;

    // Count completion pulses seen at clock edges
    always @(posedge clk) begin
        if (rst && GHASH_done) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Textbook bit-serial GF(2^128) product (GCM bit order)
    function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z = '0;
        logic [127:0] v = x;
        for (int i = 0; i < 128; i++) begin
            if (y[127 - i]) z ^= v;
            v = v[0] ? ((v >> 1) ^ (128'hE1 << 120)) : (v >> 1);
        end
        return z;
    endfunction

    // Plain sequential GHASH: Y = (Y ^ X_i) * H for every block
    function automatic logic [127:0] ref_ghash(input logic [127:0] h);
        logic [127:0] y = '0;
        foreach (msg[i]) y = gf_mul(y ^ msg[i], h);
        return y;
    endfunction

    task automatic send_block(input logic [127:0] x, input logic last);
        int cyc = 0;
        din = x; din_valid = 1'b1; din_last = last;
        while (!din_ready && cyc < 300) begin
            @(posedge clk); #1; cyc++;
        end
        if (!din_ready) check_eq("accept-timeout", 0, 1);
        @(posedge clk); #1;
        din_valid = 1'b0; din_last = 1'b0; din = '0;
    endtask

    task automatic run_msg(input string tag, input logic [127:0] exp, input int gap, input int hold);
        int           cyc = 0;
        int           d0 = done_cnt;
        logic         rdy_bad = 1'b0;
        logic         stable = 1'b1;
        logic [127:0] snap;
        foreach (msg[i]) begin
            repeat (gap) begin @(posedge clk); #1; end
            send_block(msg[i], i == msg.size() - 1);
        end
        while (!ghash_valid && cyc < 300) begin
            if (din_ready) rdy_bad = 1'b1;
            @(posedge clk); #1; cyc++;
        end
        check_eq({tag, "-valid"}, ghash_valid, 1);
        check_eq({tag, "-latency"}, cyc, c_N);
        check_eq({tag, "-rdy-quiet"}, rdy_bad, 0);
        snap = ghash;
        repeat (hold) begin
            @(posedge clk); #1;
            if (ghash !== snap || !ghash_valid || din_ready) stable = 1'b0;
        end
        if (hold > 0) check_eq({tag, "-stable"}, stable, 1);
        check_eq({tag, "-ghash"}, ghash, exp);
        ghash_ready = 1'b1; #1;
        check_eq({tag, "-done"}, GHASH_done, 1);
        @(posedge clk); #1;
        ghash_ready = 1'b0;
        check_eq({tag, "-released"}, ghash_valid, 0);
        check_eq({tag, "-done-once"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        rst = 1'b0; h1 = c_H; h2 = c_H2; h_valid = 1'b0;
        din = '0; din_valid = 1'b0; din_last = 1'b0; ghash_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst-ready", din_ready, 0);
        check_eq("rst-valid", ghash_valid, 0);
        check_eq("rst-ghash", ghash, 0);
        check_eq("rst-done", GHASH_done, 0);
        rst = 1'b1; h_valid = 1'b1;

        msg = '{128'h0};                      run_msg("zero",  128'h0, 0, 0);
        msg = '{c_ONE};                       run_msg("one",   c_H,    0, 0);
        msg = '{c_ONE, 128'h0};               run_msg("p10",   c_H2,   0, 0);
        msg = '{128'h0, c_ONE};               run_msg("p01",   c_H,    0, 0);
        msg = '{c_ONE, 128'h0, 128'h0, 128'h0}; run_msg("h4", c_H4,    0, 0);
        msg = '{128'h0, 128'h0, c_ONE};       run_msg("t001",  c_H,    0, 0);
        msg = '{c_ONE, 128'h0, 128'h0, 128'h0}; run_msg("gaps", c_H4,  3, 5);

        // h_valid dropped in GET1 after a nonzero partial result
        d0 = done_cnt;
        send_block(c_ONE, 1'b0); send_block(128'h0, 1'b0); send_block(c_ONE, 1'b0);
        h_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("hv-abort-ready", din_ready, 0);
        check_eq("hv-abort-y", ghash, 0);
        repeat (2) @(posedge clk); #1;
        check_eq("hv-abort-nodone", done_cnt - d0, 0);
        h_valid = 1'b1;
        msg = '{c_ONE}; run_msg("after-hv", c_H, 0, 0);

        // Reset while the second pair is multiplying
        d0 = done_cnt;
        send_block(c_ONE, 1'b0); send_block(128'h0, 1'b0);
        send_block(c_ONE, 1'b0); send_block(128'h0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rst-mul-y", ghash, 0);
        check_eq("rst-mul-valid", ghash_valid, 0);
        check_eq("rst-mul-ready", din_ready, 0);
        rst = 1'b1;
        repeat (c_N + 2) @(posedge clk); #1;
        check_eq("rst-mul-nodone", done_cnt - d0, 0);
        msg = '{c_ONE}; run_msg("after-rst", c_H, 0, 0);

        // Random keys and messages against the sequential model
        for (int m = 0; m < 8; m++) begin
            logic [127:0] h;
            int           len;
            h   = {$urandom, $urandom, $urandom, $urandom};
            h1  = h;
            h2  = gf_mul(h, h);
            len = $urandom_range(1, 6);
            msg = {};
            for (int k = 0; k < len; k++) msg.push_back({$urandom, $urandom, $urandom, $urandom});
            run_msg($sformatf("rnd%0d", m), ref_ghash(h), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
